// File: rtl/sisc_fetch_if.sv
// rtl/sisc_fetch_if.sv - instruction memory req/ack bus for the SISC fetch stage
interface sisc_fetch_if #(
  parameter int AW = 16
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/sisc_fetch.sv
// rtl/sisc_fetch.sv - SISC fetch stage: pc, IR, imem handshake and branch resolution
module sisc_fetch #(
  parameter int AW          = 16,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_go,
  input  logic          br_eval,
  input  logic [3:0]    stat,
  sisc_fetch_if.master  mem,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [3:0]    rd,
  output logic [3:0]    rs,
  output logic [3:0]    rt,
  output logic [15:0]   imm,
  output logic [AW-1:0] pc,
  output logic          ir_valid,
  output logic          branch_taken,
  output logic          halted,
  output logic          err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  localparam int            CW   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

  logic [31:0]   ir;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          cond;
  logic          br_hit;
  logic          take_br;
  logic [AW-1:0] br_target;

  assign opcode = ir[31:28];
  assign mm     = ir[27:24];
  assign rd     = ir[23:20];
  assign rs     = ir[19:16];
  assign rt     = ir[15:12];
  assign imm    = ir[15:0];

  assign mem.imem_req  = (state == REQ);
  assign mem.imem_addr = pc;

  // BRR/BNR (odd opcodes) are pc-relative to the already-incremented pc
  always_comb begin
    cond      = |(mm & stat);
    br_hit    = 1'b0;
    br_target = imm[AW-1:0];
    case (opcode)
      4'd4:    br_hit = cond;
      4'd5:    br_hit = cond;
      4'd6:    br_hit = !cond;
      4'd7:    br_hit = !cond;
      default: br_hit = 1'b0;
    endcase
    if (opcode[0]) br_target = pc + imm[AW-1:0];
    take_br = (state == IDLE) && ir_valid && br_eval && br_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= '0;
      ir           <= '0;
      ir_valid     <= 1'b0;
      branch_taken <= 1'b0;
      halted       <= 1'b0;
      err          <= 1'b0;
      cnt          <= '0;
    end else begin
      branch_taken <= 1'b0;
      case (state)
        IDLE: begin
          if (take_br) begin
            pc           <= br_target;
            branch_taken <= 1'b1;
          end
          // a same-cycle branch and fetch both land here; the request then sees the new pc
          if (fetch_go && !halted && !err) begin
            state    <= REQ;
            ir_valid <= 1'b0;
            cnt      <= '0;
          end
        end
        REQ: begin
          if (mem.imem_ack) begin
            ir       <= mem.imem_rdata;
            pc       <= pc + AW'(1);
            ir_valid <= 1'b1;
            state    <= IDLE;
            if (mem.imem_rdata[31:28] == 4'hF) halted <= 1'b1;
          end else if (cnt == LAST) begin
            state <= FAULT;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FAULT: state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sisc_fetch.sv
// tb/tb_sisc_fetch.sv - directed table-driven bench for sisc_fetch
module tb_sisc_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_go = 1'b0;
  logic        br_eval = 1'b0;
  logic [3:0]  stat = 4'h0;
  logic [3:0]  opcode, mm, rd, rs, rt;
  logic [15:0] imm;
  logic [15:0] pc;
  logic        ir_valid, branch_taken, halted, err;

  int n_tests = 0;
  int n_fail  = 0;

  sisc_fetch_if #(.AW(16)) bus ();

  sisc_fetch #(.AW(16), .ACK_TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_go     (fetch_go),
    .br_eval      (br_eval),
    .stat         (stat),
    .mem          (bus),
    .opcode       (opcode),
    .mm           (mm),
    .rd           (rd),
    .rs           (rs),
    .rt           (rt),
    .imm          (imm),
    .pc           (pc),
    .ir_valid     (ir_valid),
    .branch_taken (branch_taken),
    .halted       (halted),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] rdata;
    logic [3:0]  stat;
    logic [15:0] exp_addr;
    logic [3:0]  exp_op;
    logic [15:0] exp_pc;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[11];
  logic [15:0] last_addr;
  int n_req;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] data, input int waits);
    fetch_go = 1'b1;
    tick();
    fetch_go  = 1'b0;
    last_addr = bus.imem_addr;
    repeat (waits) tick();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
  endtask

  task automatic do_branch();
    br_eval = 1'b1;
    tick();
    br_eval = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'h42000040, 4'h2, 16'h0001, 4'h4, 16'h0040, 1'b1};
    vecs[1]  = '{32'h42000040, 4'h1, 16'h0040, 4'h4, 16'h0041, 1'b0};
    vecs[2]  = '{32'h4F000004, 4'hF, 16'h0041, 4'h4, 16'h0004, 1'b1};
    vecs[3]  = '{32'h7100FFFE, 4'h0, 16'h0004, 4'h7, 16'h0003, 1'b1};
    vecs[4]  = '{32'h61000020, 4'h1, 16'h0003, 4'h6, 16'h0004, 1'b0};
    vecs[5]  = '{32'h61000020, 4'h0, 16'h0004, 4'h6, 16'h0020, 1'b1};
    vecs[6]  = '{32'h53000010, 4'h2, 16'h0020, 4'h5, 16'h0031, 1'b1};
    vecs[7]  = '{32'h5300FFF0, 4'h4, 16'h0031, 4'h5, 16'h0032, 1'b0};
    vecs[8]  = '{32'h7800FFF0, 4'h0, 16'h0032, 4'h7, 16'h0023, 1'b1};
    vecs[9]  = '{32'h4F00FFFF, 4'h1, 16'h0023, 4'h4, 16'hFFFF, 1'b1};
    vecs[10] = '{32'h00000000, 4'hF, 16'hFFFF, 4'h0, 16'h0000, 1'b0};

    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_pc", pc, 0);
    chk("rst_fields", {opcode, mm, rd, rs, imm}, 0);
    chk("rst_flags", {bus.imem_req, ir_valid, branch_taken, halted, err}, 0);

    // first fetch: ack two cycles into the request
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    chk("f0_req", bus.imem_req, 1);
    chk("f0_addr", bus.imem_addr, 0);
    chk("f0_valid_clr", ir_valid, 0);
    tick();
    tick();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h88123005;
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    chk("f0_fields", {opcode, mm, rd, rs, rt}, 20'h88123);
    chk("f0_imm", imm, 16'h3005);
    chk("f0_pc", pc, 1);
    chk("f0_valid_req", {ir_valid, bus.imem_req}, 2'b10);

    for (int i = 0; i < 11; i++) begin
      stat = vecs[i].stat;
      do_fetch(vecs[i].rdata, i % 3);
      chk($sformatf("v%0d_addr", i), last_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_op", i), opcode, vecs[i].exp_op);
      do_branch();
      chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_taken", i), branch_taken, vecs[i].exp_taken);
      tick();
      chk($sformatf("v%0d_taken_drop", i), branch_taken, 0);
    end

    // fetch_go and br_eval on the same edge: request goes to the branch target
    stat = 4'hF;
    do_fetch(32'h4F000123, 0);
    chk("same_pre_pc", pc, 16'h0001);
    fetch_go = 1'b1;
    br_eval  = 1'b1;
    tick();
    fetch_go = 1'b0;
    br_eval  = 1'b0;
    chk("same_addr", bus.imem_addr, 16'h0123);
    chk("same_taken_req", {branch_taken, bus.imem_req}, 2'b11);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h10000000;
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    chk("same_pc", pc, 16'h0124);
    chk("same_op", opcode, 1);

    // ack in the last allowed request cycle is accepted
    do_fetch(32'h20000000, 7);
    chk("late_ack_pc", pc, 16'h0125);
    chk("late_ack_flags", {err, ir_valid, opcode}, {1'b0, 1'b1, 4'h2});

    // no ack: request held exactly ACK_TIMEOUT cycles, IR stable meanwhile
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    chk("to_ir_stable", opcode, 2);
    n_req = 0;
    for (int k = 0; k < 20; k++) begin
      if (!bus.imem_req) break;
      n_req++;
      tick();
    end
    chk("to_req_cycles", n_req, 8);
    chk("to_err", {err, bus.imem_req}, 2'b10);
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    tick();
    chk("fault_no_req", {err, bus.imem_req}, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("fault_rst", {err, pc}, 0);

    // HLT sets halted on the ack edge and blocks later fetches
    do_fetch(32'hF0000000, 0);
    chk("hlt_flag", {halted, opcode}, {1'b1, 4'hF});
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    chk("hlt_no_req", bus.imem_req, 0);
    tick();
    chk("hlt_no_req2", bus.imem_req, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("hlt_rst", halted, 0);

    // reset in the middle of a request
    do_fetch(32'h30000000, 0);
    chk("mid_pre_pc", pc, 1);
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    tick();
    chk("mid_req", bus.imem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst", {bus.imem_req, ir_valid, pc, opcode}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
